// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM data-port arbiter.
package sram_arb_pkg;
  localparam int STALL_CNT_W = 16;
  localparam int MAX_MASTERS = 4;

  typedef logic [1:0] master_id_t;

  // Index 'k' positions after 'base' in a ring of 'n' masters (base, k < n).
  function automatic int rr_idx(master_id_t base, int k, int n);
    int s;
    s = int'(base) + k;
    return (s >= n) ? s - n : s;
  endfunction
endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order queue of transaction owner IDs; a pop frees the slot for a same-cycle push when full.
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  master_id_t id_i,
  output master_id_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  master_id_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign head_o  = r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= id_i;

endmodule

// File: rtl/sram_d_arbiter.sv
// Round-robin arbiter sharing the SRAM data OBI port among NUM_MASTERS requesters.
// Define SRAM_ARB_STATS_EN to build the per-master saturating stall counters.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NUM_MASTERS-1:0]                  m_req_i,
  output logic [NUM_MASTERS-1:0]                  m_gnt_o,
  input  logic [NUM_MASTERS-1:0][31:0]            m_addr_i,
  input  logic [NUM_MASTERS-1:0]                  m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]             m_be_i,
  input  logic [NUM_MASTERS-1:0][31:0]            m_wdata_i,
  output logic [NUM_MASTERS-1:0]                  m_rvalid_o,
  output logic [NUM_MASTERS-1:0][31:0]            m_rdata_o,
  output logic                                    s_req_o,
  input  logic                                    s_gnt_i,
  output logic [31:0]                             s_addr_o,
  output logic                                    s_we_o,
  output logic [3:0]                              s_be_o,
  output logic [31:0]                             s_wdata_o,
  input  logic                                    s_rvalid_i,
  input  logic [31:0]                             s_rdata_i,
  output logic                                    proto_err_o,
  output logic [NUM_MASTERS-1:0][STALL_CNT_W-1:0] stall_cnt_o
);

  master_id_t r_rr_ptr, w_win_id, w_head;
  logic       r_first_cyc, r_perr;
  logic       w_win_vld, w_full, w_empty, w_pop, w_accept;

  // Later (lower k) matches overwrite earlier ones, so the nearest requester at/after rr_ptr wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      for (int i = 0; i < NUM_MASTERS; i++)
        if (m_req_i[i] && i == rr_idx(r_rr_ptr, k, NUM_MASTERS)) begin
          w_win_vld = 1'b1;
          w_win_id  = master_id_t'(i);
        end
  end

  assign w_pop    = s_rvalid_i && !rst_i && !w_empty;
  assign s_req_o  = !rst_i && w_win_vld && (!w_full || w_pop);
  assign w_accept = s_req_o && s_gnt_i;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_gnt_o   = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (w_win_vld && w_win_id == master_id_t'(i)) begin
        s_addr_o   = m_addr_i[i];
        s_we_o     = m_we_i[i];
        s_be_o     = m_be_i[i];
        s_wdata_o  = m_wdata_i[i];
        m_gnt_o[i] = w_accept;
      end
  end

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (w_pop && w_head == master_id_t'(i)) begin
        m_rvalid_o[i] = 1'b1;
        m_rdata_o[i]  = s_rdata_i;
      end
  end

  // r_first_cyc marks the cycle right after reset, when a stray response is dropped silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_first_cyc <= 1'b1;
      r_perr      <= 1'b0;
    end else begin
      r_first_cyc <= 1'b0;
      if (w_accept) r_rr_ptr <= master_id_t'(rr_idx(w_win_id, 1, NUM_MASTERS));
      if (s_rvalid_i && w_empty && !r_first_cyc) r_perr <= 1'b1;
    end
  end

  assign proto_err_o = r_perr;

  sram_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .id_i    (w_win_id),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef SRAM_ARB_STATS_EN
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stall
    logic [STALL_CNT_W-1:0] r_cnt;
    always_ff @(posedge clk_i) begin
      if (rst_i) r_cnt <= '0;
      else if (m_req_i[g] && !m_gnt_o[g] && r_cnt != '1) r_cnt <= r_cnt + STALL_CNT_W'(1);
    end
    assign stall_cnt_o[g] = r_cnt;
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Bench for sram_d_arbiter: directed vector table, stall-count sequence, then random traffic vs a queue model.
module tb_sram_d_arbiter;
  import sram_arb_pkg::*;

  localparam int N = 2;
  localparam int D = 2;
`ifdef SRAM_ARB_STATS_EN
  localparam logic [15:0] EXP_STALL7 = 16'd7;
`else
  localparam logic [15:0] EXP_STALL7 = 16'd0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       m_req, m_gnt, m_we, m_rvalid;
  logic [N-1:0][31:0] m_addr, m_wdata, m_rdata;
  logic [N-1:0][3:0]  m_be;
  logic               s_req, s_gnt, s_we, s_rvalid, perr;
  logic [31:0]        s_addr, s_wdata, s_rdata;
  logic [3:0]         s_be;
  logic [N-1:0][15:0] stall;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: owner queue, ring pointer, sticky error, first-cycle flag, stall counts.
  int mq[$];
  int m_rr    = 0;
  bit m_perr  = 1'b0;
  bit m_first = 1'b1;
  int m_stall [N];

  always #5 clk = ~clk;

  sram_d_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .proto_err_o(perr), .stall_cnt_o(stall)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        sg;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic        e_sreq;
    logic [31:0] e_saddr;
    logic [1:0]  e_rvld;
    logic [63:0] e_rdata;
    logic        e_perr;
  } vec_t;

  vec_t tv [26];

  function automatic vec_t mk(logic r, logic [1:0] rq, logic sg, logic rv, logic [31:0] rd,
                              logic [1:0] eg, logic es, logic [31:0] ea, logic [1:0] erv,
                              logic [31:0] erd1, logic [31:0] erd0, logic ep);
    vec_t v;
    v.rst = r; v.req = rq; v.sg = sg; v.rv = rv; v.rdata = rd;
    v.e_gnt = eg; v.e_sreq = es; v.e_saddr = ea; v.e_rvld = erv;
    v.e_rdata = {erd1, erd0}; v.e_perr = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Checks DUT outputs against the model for the current inputs, then advances the model one clock.
  task automatic model_step();
    int                 win;
    bit                 pop, e_sreq;
    logic [N-1:0]       e_gnt, e_rv;
    logic [N-1:0][31:0] e_rd;
    logic [N-1:0][15:0] e_st;
    logic [31:0]        e_addr, e_wd;
    logic               e_we;
    logic [3:0]         e_be;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && m_req[(m_rr + k) % N]) win = (m_rr + k) % N;
    pop    = !rst && s_rvalid && mq.size() > 0;
    e_sreq = !rst && win >= 0 && (mq.size() < D || pop);
    e_gnt = '0; e_addr = '0; e_wd = '0; e_we = 1'b0; e_be = '0;
    if (win >= 0) begin
      e_addr = m_addr[win]; e_wd = m_wdata[win]; e_we = m_we[win]; e_be = m_be[win];
      if (e_sreq && s_gnt) e_gnt[win] = 1'b1;
    end
    e_rv = '0; e_rd = '0;
    if (pop) begin
      e_rv[mq[0]] = 1'b1;
      e_rd[mq[0]] = s_rdata;
    end
    for (int i = 0; i < N; i++) e_st[i] = 16'(m_stall[i]);
    chk("m_gnt", 64'(m_gnt), 64'(e_gnt));
    chk("s_req", 64'(s_req), 64'(e_sreq));
    chk("s_addr", 64'(s_addr), 64'(e_addr));
    chk("s_we", 64'(s_we), 64'(e_we));
    chk("s_be", 64'(s_be), 64'(e_be));
    chk("s_wdata", 64'(s_wdata), 64'(e_wd));
    chk("m_rvalid", 64'(m_rvalid), 64'(e_rv));
    chk("m_rdata", 64'(m_rdata), 64'(e_rd));
    chk("proto_err", 64'(perr), 64'(m_perr));
    chk("stall_cnt", 64'(stall), 64'(e_st));
    if (rst) begin
      mq.delete();
      m_rr   = 0;
      m_perr = 1'b0;
      for (int i = 0; i < N; i++) m_stall[i] = 0;
    end else begin
      if (s_rvalid && mq.size() == 0 && !m_first) m_perr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (e_gnt != '0) begin
        mq.push_back(win);
        m_rr = (win + 1) % N;
      end
`ifdef SRAM_ARB_STATS_EN
      for (int i = 0; i < N; i++)
        if (m_req[i] && !e_gnt[i] && m_stall[i] < 65535) m_stall[i]++;
`endif
    end
    m_first = rst;
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    localparam logic [31:0] A = 32'h8000_0010;
    localparam logic [31:0] B = 32'h8000_0020;
    for (int i = 0; i < N; i++) m_stall[i] = 0;
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    m_addr[0] = A; m_addr[1] = B;
    m_we = 2'b10; m_be[0] = 4'hF; m_be[1] = 4'h3;
    m_wdata[0] = 32'h0; m_wdata[1] = 32'h1111_2222;

    //            rst   req    sg    rv    rdata          gnt    sreq  saddr  rvld   rdata[1]      rdata[0]      perr
    tv[0]  = mk(1'b1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[1]  = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b0);
    tv[2]  = mk(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[3]  = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hCAFE_0001, 2'b00, 1'b0, 32'h0, 2'b01, 32'h0,        32'hCAFE_0001,1'b0);
    tv[4]  = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b0);
    tv[5]  = mk(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[6]  = mk(1'b0, 2'b11, 1'b1, 1'b1, 32'hA0A0_0000, 2'b10, 1'b1, B,     2'b01, 32'h0,        32'hA0A0_0000,1'b0);
    tv[7]  = mk(1'b0, 2'b11, 1'b1, 1'b1, 32'hA1A1_0001, 2'b01, 1'b1, A,     2'b10, 32'hA1A1_0001,32'h0,        1'b0);
    tv[8]  = mk(1'b0, 2'b11, 1'b1, 1'b1, 32'hA2A2_0002, 2'b10, 1'b1, B,     2'b01, 32'h0,        32'hA2A2_0002,1'b0);
    tv[9]  = mk(1'b0, 2'b11, 1'b0, 1'b1, 32'hA3A3_0003, 2'b00, 1'b1, A,     2'b10, 32'hA3A3_0003,32'h0,        1'b0);
    tv[10] = mk(1'b0, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[11] = mk(1'b0, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[12] = mk(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[13] = mk(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, B,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[14] = mk(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A,     2'b00, 32'h0,        32'h0,        1'b0);
    tv[15] = mk(1'b0, 2'b11, 1'b1, 1'b1, 32'hB0B0_0000, 2'b01, 1'b1, A,     2'b01, 32'h0,        32'hB0B0_0000,1'b0);
    tv[16] = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hB1B1_0001, 2'b00, 1'b0, 32'h0, 2'b10, 32'hB1B1_0001,32'h0,        1'b0);
    tv[17] = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hB2B2_0002, 2'b00, 1'b0, 32'h0, 2'b01, 32'h0,        32'hB2B2_0002,1'b0);
    tv[18] = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'h5555_5555, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b0);
    tv[19] = mk(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b1);
    tv[20] = mk(1'b0, 2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, B,     2'b00, 32'h0,        32'h0,        1'b1);
    tv[21] = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hC1C1_0001, 2'b00, 1'b0, 32'h0, 2'b10, 32'hC1C1_0001,32'h0,        1'b1);
    tv[22] = mk(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, A,     2'b00, 32'h0,        32'h0,        1'b1);
    tv[23] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b1);
    tv[24] = mk(1'b0, 2'b00, 1'b1, 1'b1, 32'hD0D0_0000, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b0);
    tv[25] = mk(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        32'h0,        1'b0);

    for (int t = 0; t < 26; t++) begin
      rst = tv[t].rst; m_req = tv[t].req; s_gnt = tv[t].sg;
      s_rvalid = tv[t].rv; s_rdata = tv[t].rdata;
      @(negedge clk);
      chk("tv_gnt", 64'(m_gnt), 64'(tv[t].e_gnt));
      chk("tv_sreq", 64'(s_req), 64'(tv[t].e_sreq));
      chk("tv_saddr", 64'(s_addr), 64'(tv[t].e_saddr));
      chk("tv_rvalid", 64'(m_rvalid), 64'(tv[t].e_rvld));
      chk("tv_rdata", 64'(m_rdata), tv[t].e_rdata);
      chk("tv_perr", 64'(perr), 64'(tv[t].e_perr));
      model_step();
      @(posedge clk);
      #1;
    end

    // M1 alone, slave refusing grants for 7 cycles, then one grant and its response.
    m_req = 2'b10; s_gnt = 1'b0; s_rvalid = 1'b0;
    repeat (7) run_cycle();
    s_gnt = 1'b1;
    @(negedge clk);
    chk("stall_cnt1_after7", 64'(stall[1]), 64'(EXP_STALL7));
    chk("stall_cnt0_idle", 64'(stall[0]), 64'h0);
    chk("m1_gnt_after_stall", 64'(m_gnt), 64'(2'b10));
    model_step();
    @(posedge clk);
    #1;
    m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    run_cycle();
    s_rvalid = 1'b0;

    // Random traffic with variable response latency and occasional reset.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      m_req = 2'($urandom);
      for (int i = 0; i < N; i++) begin
        m_addr[i]  = $urandom();
        m_wdata[i] = $urandom();
        m_we[i]    = 1'($urandom);
        m_be[i]    = 4'($urandom);
      end
      s_gnt    = ($urandom_range(0, 3) != 0);
      s_rvalid = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      s_rdata  = $urandom();
      run_cycle();
    end

    rst = 1'b0; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
